// File: rtl/reg_bus_pkg.sv
// Shared types and widths for the register-bus arbiter.
package reg_bus_pkg;

  localparam int REG_ADDR_W = 8;
  localparam int REG_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: the pointer remembers the last granted index
// so that a tie goes to the other requester.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic       win_o,
  output logic       any_o
);

  logic ptr_q;

  always_comb begin
    any_o = |req_i;
    case (req_i)
      2'b01:   win_o = 1'b0;
      2'b10:   win_o = 1'b1;
      2'b11:   win_o = ~ptr_q;
      default: win_o = 1'b0;
    endcase
  end

  // Reset value 1 lets requester 0 win the first tie.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q <= 1'b1;
    end else if (take_i && any_o) begin
      ptr_q <= win_o;
    end
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Arbitrates two requesters onto a single register bus; one transaction at a
// time, strobe -> optional wait -> one-cycle ack with sampled read data.
module reg_bus_arbiter
  import reg_bus_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  wr0,
  input  logic                  wr1,
  input  logic [REG_ADDR_W-1:0] addr0,
  input  logic [REG_ADDR_W-1:0] addr1,
  input  logic [REG_DATA_W-1:0] wdata0,
  input  logic [REG_DATA_W-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [REG_DATA_W-1:0] rdata,
  output logic [1:0]            gnt,
  output logic [REG_ADDR_W-1:0] reg_addr,
  output logic [REG_DATA_W-1:0] reg_wdata,
  input  logic [REG_DATA_W-1:0] reg_rdata,
  output logic                  reg_wr,
  output logic                  reg_rd
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t                state_q;
  logic [3:0]            cnt_q;
  logic                  idx_q;
  logic                  wr_q;
  logic [REG_ADDR_W-1:0] addr_q;
  logic [REG_DATA_W-1:0] wdata_q;
  logic [1:0]            gnt_q;
  logic [1:0]            ack_q;
  logic [REG_DATA_W-1:0] rdata_q;
  logic                  reg_wr_q;
  logic                  reg_rd_q;

  logic                  win;
  logic                  any_req;
  logic                  wr_d;
  logic [REG_ADDR_W-1:0] addr_d;
  logic [REG_DATA_W-1:0] wdata_d;
  logic [REG_DATA_W-1:0] rdata_d;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req_i   ({req1, req0}),
    .take_i  (state_q == ST_IDLE),
    .win_o   (win),
    .any_o   (any_req)
  );

  assign wr_d    = win ? wr1 : wr0;
  assign addr_d  = win ? addr1 : addr0;
  assign wdata_d = win ? wdata1 : wdata0;
  assign rdata_d = wr_q ? '0 : reg_rdata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      rdata_q  <= '0;
      reg_wr_q <= 1'b0;
      reg_rd_q <= 1'b0;
    end else begin
      reg_wr_q <= 1'b0;
      reg_rd_q <= 1'b0;
      ack_q    <= '0;
      rdata_q  <= '0;
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            state_q  <= ST_ISSUE;
            idx_q    <= win;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            gnt_q    <= onehot2(win);
            reg_wr_q <= wr_d;
            reg_rd_q <= ~wr_d;
          end
        end
        ST_ISSUE: begin
          if (WAIT_CYCLES == 0) begin
            state_q <= ST_ACK;
            ack_q   <= onehot2(idx_q);
            rdata_q <= rdata_d;
          end else begin
            state_q <= ST_WAIT;
            cnt_q   <= WAIT_LOAD;
          end
        end
        ST_WAIT: begin
          // Read data is captured on the edge that leaves the last wait cycle.
          if (cnt_q == 4'd0) begin
            state_q <= ST_ACK;
            ack_q   <= onehot2(idx_q);
            rdata_q <= rdata_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
          wr_q    <= 1'b0;
          addr_q  <= '0;
          wdata_q <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
          wr_q    <= 1'b0;
          addr_q  <= '0;
          wdata_q <= '0;
        end
      endcase
    end
  end

  assign ack0      = ack_q[0];
  assign ack1      = ack_q[1];
  assign rdata     = rdata_q;
  assign gnt       = gnt_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wr    = reg_wr_q;
  assign reg_rd    = reg_rd_q;

endmodule

// File: doc/reg_bus_arbiter.md
REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 Param WAIT_CYCLES, default 1: cycles between access strobe and read-data sample, range 0..15.
REQ-002 clk  input  1  sole clock, all logic on rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 req0, req1  input  1 each  transaction request; 0 = host command path, 1 = internal sequencer.
REQ-005 wr0, wr1  input  1 each  1 = write, 0 = read.
REQ-006 addr0, addr1  input  8 each  register address.
REQ-007 wdata0, wdata1  input  8 each  write data.
REQ-008 ack0, ack1  output  1 each  one-cycle completion pulse.
REQ-009 rdata  output  8  read data, valid only while an ack is high.
REQ-010 gnt  output  2  one-hot grant, high from ISSUE through ACK.
REQ-011 reg_addr  output  8  register bus address.
REQ-012 reg_wdata  output  8  register bus write data.
REQ-013 reg_rdata  input  8  register bus read data.
REQ-014 reg_wr, reg_rd  output  1 each  one-cycle access strobes.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT, ACK; unused encodings SHALL go to IDLE next cycle.
REQ-016 IDLE: if any req is high, the winner SHALL be selected, its wr/addr/wdata latched, and the FSM SHALL go to ISSUE.
REQ-017 Winner SHALL be the sole requester, or, on simultaneous requests, the requester not granted last (round-robin pointer).
REQ-018 Pointer SHALL update to the granted index on entry to ISSUE.
REQ-019 ISSUE lasts one cycle: reg_wr = latched wr, reg_rd = !latched wr; reg_addr/reg_wdata SHALL show latched values.
REQ-020 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit counter; WAIT_CYCLES = 0 goes ISSUE -> ACK directly.
REQ-021 reg_addr/reg_wdata SHALL hold latched values from ISSUE through ACK, and be 0 in IDLE.
REQ-022 ACK lasts one cycle: ack of granted requester = 1; rdata = reg_rdata sampled on the last WAIT edge (ISSUE edge if WAIT_CYCLES = 0) for reads, 0 for writes; next state IDLE.
REQ-023 Latency: req sampled in IDLE at edge T -> strobe in cycle T+1 -> ack in cycle T+2+WAIT_CYCLES; back-to-back grants SHALL be possible with no idle cycle beyond the IDLE cycle.
REQ-024 Requesters SHALL drop req in the cycle after ack; req still high in IDLE is a new transaction.
REQ-025 Input changes on a granted requester after the latch SHALL NOT affect the transaction.
REQ-026 A req dropped by a non-granted requester SHALL be ignored (no ack).
REQ-027 rdata SHALL be 0 whenever neither ack is high.
REQ-028 At most one ack, one gnt bit and one strobe SHALL be high in any cycle.

Reset
REQ-029 reset_n low at an edge: state IDLE, pointer = 1 (requester 0 wins first tie), counter 0, latches 0.
REQ-030 All outputs SHALL be 0 in the cycle after a reset edge.
REQ-031 Reset mid-transaction SHALL abort without ack or further strobe.

Structure
REQ-032 Package reg_bus_pkg SHALL hold state encoding, REG_ADDR_W = 8 and REG_DATA_W = 8.
REQ-033 Sub-module rr_arb2 SHALL hold the round-robin pointer and winner selection; the FSM, counter and latches stay in reg_bus_arbiter.

Verification
REQ-034 W=1, reset; req0 write addr 0x12 data 0xA5 at edge T -> reg_wr=1, reg_addr=0x12, reg_wdata=0xA5 in T+1; ack0 in T+3; rdata=0.
REQ-035 W=1; req1 read addr 0x05, bus returns 0x3C -> reg_rd in T+1, ack1 with rdata=0x3C in T+3.
REQ-036 After reset, req0 and req1 held continuously -> grants 0,1,0,1; each requester drops req after ack and re-asserts it -> no double ack.
REQ-037 W=0 read -> ack in T+2; W=3 read -> ack in T+5; rdata equals reg_rdata sampled on the correct edge.
REQ-038 reset_n low during WAIT -> all outputs 0 next cycle, no ack; a fresh req0 then completes normally, winning a tie.
REQ-039 Change addr0 to 0x99 during WAIT -> reg_addr stays at the latched value until ACK.
